lfsr_wb_sequencer: RTL and testbench
====================================

# lfsr_wb_sequencer

Wishbone master that drives the LFSR Wishbone peripheral: optionally reseeds it, then reads a run of single-bit outputs and packs them into a word. It sits between a simple start/done request port (CPU glue or a test harness) and the peripheral's slave bus. It also makes sure seed loading always uses the same byte-write and control-write sequence.

## Interface
- WORD_W, 32, bits collected per request (1..32)
- TIMEOUT, 15, max cycles waiting for ack after stb accepted before abort (1..255)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  request pulse, sampled only in IDLE
- i_reseed  in  1  sampled with i_start: 1 = perform seed load before collecting
- i_seed  in  32  seed value, captured with i_start
- o_busy  out  1  high from cycle after accepted i_start until return to IDLE
- o_word  out  WORD_W  last completed word, held until next completion
- o_valid  out  1  one-cycle pulse when o_word updates
- o_err  out  1  one-cycle pulse on ack timeout
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls
- o_wb_addr  out  3  slave register address
- o_wb_data  out  8  write data
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave ack
- i_wb_data  in  1  read data (one LFSR bit)

## Operation
- States: IDLE, ISSUE, WAIT_ACK, DONE.
- IDLE: on i_start, capture i_seed and i_reseed, clear op index and bit count, go to ISSUE. i_start is ignored in all other states.
- Op list when reseed=1, one Wishbone write each:
  - addr 0..3 get seed[7:0], [15:8], [23:16], [31:24].
  - addr 4 gets 0x02 (load_seed=1, lfsr_reset=0).
  - addr 4 gets 0x00 (release).
  - Then WORD_W reads at addr 0.
- When reseed=0: WORD_W reads only.
- ISSUE: cyc=stb=1, with we/addr/data for the current op. If i_wb_stall=1, hold everything unchanged. If i_wb_stall=0, stb drops next cycle and state goes to WAIT_ACK with cyc still held.
- WAIT_ACK: on i_wb_ack, complete the op.
  - For a read, shift_reg <= {shift_reg[WORD_W-2:0], i_wb_data}, so the first bit read ends up in the MSB.
  - If ops remain, go to ISSUE with cyc kept high. Otherwise drop cyc and go to DONE.
- Timeout: a counter starts at 0 on entry to WAIT_ACK. If it reaches TIMEOUT with no ack:
  - drop cyc/stb, pulse o_err, go to IDLE;
  - o_word is unchanged and no o_valid.
- DONE: o_word <= shift_reg, pulse o_valid, go to IDLE.
- The op index counts to 6 + WORD_W (max 38) and needs 6 bits.
- An ack seen in ISSUE, or while cyc=0, is ignored.

## Timing
- Reset (async assert, any state): state=IDLE. All outputs 0: cyc, stb, we, addr, data, o_word, o_valid, o_err, o_busy. An in-flight transaction is abandoned immediately.
- Deassertion is synchronous to i_clk. The first i_start is accepted on the first edge with i_reset_n=1.
- Bus outputs are registered. With i_start high in cycle 0, stb is high in cycle 1.
- With a zero-stall slave that acks one cycle after stb, transaction k has stb in cycle 1+2k and ack in cycle 2+2k. With N total ops, o_valid is high in cycle 2N+1.
  - WORD_W=32, reseed=0: o_valid in cycle 65.
  - WORD_W=32, reseed=1: o_valid in cycle 77.
- Each stall cycle adds one cycle. Each extra ack-wait cycle adds one cycle.
- o_busy is high from cycle 1 through the cycle o_valid or o_err pulses, and low the following cycle.
- i_start is re-accepted in the first IDLE cycle after completion. Back-to-back requests have a 1-cycle gap.
- i_seed and i_reseed changes after capture have no effect on the current run.

## Test plan
- Reset mid-run: assert i_reset_n=0 during a WAIT_ACK read -> all outputs 0 in the same cycle. After release, a new start runs a full sequence.
- Reseed, WORD_W=32, i_seed=0xDEADBEEF, zero-stall model slave:
  - writes observed in order (0,0xEF), (1,0xBE), (2,0xAD), (3,0xDE), (4,0x02), (4,0x00), then 32 reads;
  - o_valid in cycle 77.
- No reseed, WORD_W=8, slave returns bits 1,0,1,1,0,0,1,0 -> o_word=0xB2, o_valid in cycle 17, o_busy low in cycle 18.
- Stall: slave holds i_wb_stall=1 for 3 cycles on the first op -> stb/addr/data stable across the stall, and o_valid is 3 cycles later than the no-stall case.
- Timeout: slave never acks the 3rd op, TIMEOUT=15 -> o_err pulses once, cyc=0, o_word keeps its prior value, no o_valid, state returns to IDLE.
- i_start asserted while busy -> ignored; the word count and the op sequence are unaffected.

Source files
------------

// File: rtl/lfsr_wb_sequencer.sv
// Wishbone master for the LFSR peripheral: optional six-write seed load, then
// WORD_W single-bit reads packed MSB-first into o_word.
module lfsr_wb_sequencer #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_reseed,
  input  logic [31:0]       i_seed,
  output logic              o_busy,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  output logic              o_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [2:0]        o_wb_addr,
  output logic [7:0]        o_wb_data,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_reseed;
  logic [31:0]       r_seed;
  logic [5:0]        r_idx, w_idx_nxt, w_last;
  logic [7:0]        r_tmo, w_tmo_nxt;
  logic [WORD_W-1:0] r_shift, w_shift_nxt, r_word, w_word_nxt, w_shift_in;
  logic              r_cyc, w_cyc_nxt, r_stb, w_stb_nxt, r_we, w_we_nxt;
  logic [2:0]        r_addr, w_addr_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt, r_err, w_err_nxt, r_busy, w_busy_nxt;
  logic [11:0]       w_op;

  // {we, addr, data} for op number idx; everything past the seed load is a read of addr 0
  function automatic logic [11:0] op_decode(input logic reseed, input logic [31:0] seed,
                                            input logic [5:0] idx);
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    we = 1'b0; addr = 3'd0; data = 8'h00;
    if (reseed && idx < 6'd6) begin
      we = 1'b1;
      case (idx)
        6'd0:    begin addr = 3'd0; data = seed[7:0];   end
        6'd1:    begin addr = 3'd1; data = seed[15:8];  end
        6'd2:    begin addr = 3'd2; data = seed[23:16]; end
        6'd3:    begin addr = 3'd3; data = seed[31:24]; end
        6'd4:    begin addr = 3'd4; data = 8'h02;       end
        default: begin addr = 3'd4; data = 8'h00;       end
      endcase
    end
    return {we, addr, data};
  endfunction

  assign w_last     = r_reseed ? 6'(WORD_W + 5) : 6'(WORD_W - 1);
  assign w_shift_in = (r_shift << 1) | WORD_W'(i_wb_data);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tmo_nxt   = r_tmo;
    w_shift_nxt = r_shift;
    w_word_nxt  = r_word;
    w_cyc_nxt   = r_cyc;
    w_stb_nxt   = r_stb;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_op        = '0;
    case (r_state)
      IDLE: if (i_start) begin
        w_op        = op_decode(i_reseed, i_seed, 6'd0);
        w_state_nxt = ISSUE;
        w_idx_nxt   = 6'd0;
        w_shift_nxt = '0;
        w_cyc_nxt   = 1'b1;
        w_stb_nxt   = 1'b1;
        {w_we_nxt, w_addr_nxt, w_data_nxt} = w_op;
      end
      ISSUE: if (!i_wb_stall) begin
        w_stb_nxt   = 1'b0;
        w_tmo_nxt   = 8'd0;
        w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_wb_ack) begin
          if (!r_we) w_shift_nxt = w_shift_in;
          if (r_idx == w_last) begin
            // last op is always a read, so the finished word is the shifted value
            w_cyc_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = 3'd0;
            w_data_nxt  = 8'h00;
            w_word_nxt  = w_shift_in;
            w_valid_nxt = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_op        = op_decode(r_reseed, r_seed, r_idx + 6'd1);
            w_idx_nxt   = r_idx + 6'd1;
            w_stb_nxt   = 1'b1;
            {w_we_nxt, w_addr_nxt, w_data_nxt} = w_op;
            w_state_nxt = ISSUE;
          end
        end else if (r_tmo == 8'(TIMEOUT - 1)) begin
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = 3'd0;
          w_data_nxt  = 8'h00;
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // busy covers the pulse cycle of o_valid / o_err as well
    w_busy_nxt = (w_state_nxt != IDLE) || w_err_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_reseed <= 1'b0;
      r_seed   <= '0;
      r_idx    <= '0;
      r_tmo    <= '0;
      r_shift  <= '0;
      r_word   <= '0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_reseed <= i_reseed;
        r_seed   <= i_seed;
      end
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tmo   <= w_tmo_nxt;
      r_shift <= w_shift_nxt;
      r_word  <= w_word_nxt;
      r_cyc   <= w_cyc_nxt;
      r_stb   <= w_stb_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_busy    = r_busy;
  assign o_word    = r_word;
  assign o_valid   = r_valid;
  assign o_err     = r_err;
  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = r_we;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_data;

endmodule

// File: tb/tb_lfsr_wb_sequencer.sv
// Directed bench: a WORD_W=32 instance for the seed-load sequence and a WORD_W=8
// instance for packing, stall, timeout, busy-start and reset behaviour.
module tb_lfsr_wb_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   cycn  = 0;
  int   t0    = 0;
  int   pass_n = 0, total_n = 0;
  always @(posedge clk) cycn <= cycn + 1;

  // WORD_W = 8 instance and its slave model
  logic       st8 = 0, rs8 = 0;
  logic [31:0] sd8 = 0;
  logic       busy8, val8, err8, cyc8, stb8, we8;
  logic [7:0] word8, dat8;
  logic [2:0] adr8;
  logic       stall8 = 0, ack8 = 0, rdat8 = 0, clr8 = 0;
  logic [63:0] pat8 = '0;
  int         op8 = 0, rd8 = 0, wr8 = 0, drop8 = -1;

  lfsr_wb_sequencer #(.WORD_W(8), .TIMEOUT(15)) u8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(st8), .i_reseed(rs8), .i_seed(sd8),
    .o_busy(busy8), .o_word(word8), .o_valid(val8), .o_err(err8),
    .o_wb_cyc(cyc8), .o_wb_stb(stb8), .o_wb_we(we8), .o_wb_addr(adr8), .o_wb_data(dat8),
    .i_wb_stall(stall8), .i_wb_ack(ack8), .i_wb_data(rdat8));

  always @(posedge clk) begin
    if (clr8) begin
      op8 <= 0; rd8 <= 0; wr8 <= 0; ack8 <= 1'b0; rdat8 <= 1'b0;
    end else begin
      ack8 <= 1'b0;
      if (cyc8 && stb8 && !stall8) begin
        op8 <= op8 + 1;
        if (op8 != drop8) ack8 <= 1'b1;
        if (we8) wr8 <= wr8 + 1;
        else begin rdat8 <= pat8[rd8[5:0]]; rd8 <= rd8 + 1; end
      end
    end
  end

  // WORD_W = 32 instance, zero-stall slave that logs writes
  logic        st32 = 0, rs32 = 0;
  logic [31:0] sd32 = 0;
  logic        busy32, val32, err32, cyc32, stb32, we32;
  logic [31:0] word32;
  logic [7:0]  dat32;
  logic [2:0]  adr32;
  logic        ack32 = 0, rdat32 = 0, bad32 = 0;
  logic [2:0]  wa32 [8];
  logic [7:0]  wd32 [8];
  int          wn32 = 0, rn32 = 0;

  lfsr_wb_sequencer #(.WORD_W(32), .TIMEOUT(15)) u32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(st32), .i_reseed(rs32), .i_seed(sd32),
    .o_busy(busy32), .o_word(word32), .o_valid(val32), .o_err(err32),
    .o_wb_cyc(cyc32), .o_wb_stb(stb32), .o_wb_we(we32), .o_wb_addr(adr32), .o_wb_data(dat32),
    .i_wb_stall(1'b0), .i_wb_ack(ack32), .i_wb_data(rdat32));

  always @(posedge clk) begin
    ack32 <= 1'b0;
    if (cyc32 && stb32) begin
      ack32 <= 1'b1;
      if (we32) begin
        if (rn32 != 0) bad32 <= 1'b1;
        if (wn32 < 8) begin wa32[wn32] <= adr32; wd32[wn32] <= dat32; end
        wn32 <= wn32 + 1;
      end else begin
        rdat32 <= (rn32 % 3 == 0);
        rn32   <= rn32 + 1;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic setpat(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < 8; i++) begin
      pat8[i]     = b0[7-i];
      pat8[8 + i] = b1[7-i];
    end
  endtask

  task automatic clear8();
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
  endtask

  // call at a negedge; that cycle is cycle 0, returns at the negedge of cycle 1
  task automatic start8(input logic reseed, input logic [31:0] seed);
    st8 = 1'b1; rs8 = reseed; sd8 = seed; t0 = cycn;
    @(negedge clk);
    st8 = 1'b0; rs8 = 1'b0; sd8 = 32'h0;
  endtask

  task automatic wait8(input int limit, output int vc, output int ec, output int bl,
                       output int nv, output int ne, output logic cyc_at_err);
    vc = -1; ec = -1; bl = -1; nv = 0; ne = 0; cyc_at_err = 1'bx;
    for (int n = 0; n < limit; n++) begin
      if (val8) begin nv++; if (vc < 0) vc = cycn - t0; end
      if (err8) begin ne++; if (ec < 0) begin ec = cycn - t0; cyc_at_err = cyc8; end end
      if ((vc >= 0 || ec >= 0) && !busy8) begin bl = cycn - t0; break; end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    clear8();
    @(negedge clk);
    total_n++;
    if ({busy8, val8, err8, cyc8, stb8, we8, adr8, dat8, word8} !== 30'h0)
      $display("FAIL reset_u8: got %h expected 0", {busy8, val8, err8, cyc8, stb8, we8, adr8, dat8, word8});
    else pass_n++;
    total_n++;
    if ({busy32, val32, err32, cyc32, stb32, we32, adr32, dat32, word32} !== 54'h0)
      $display("FAIL reset_u32: got %h expected 0", {busy32, val32, err32, cyc32, stb32, we32, adr32, dat32, word32});
    else pass_n++;
    rst_n = 1'b1;
  endtask

  task automatic test_reseed32();
    logic [2:0] ea [6];
    logic [7:0] ed [6];
    int vc;
    ea = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    ed = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h02, 8'h00};
    vc = -1;
    @(negedge clk);
    st32 = 1'b1; rs32 = 1'b1; sd32 = 32'hDEADBEEF; t0 = cycn;
    @(negedge clk);
    st32 = 1'b0; rs32 = 1'b0; sd32 = 32'h0;
    for (int n = 0; n < 200; n++) begin
      if (val32) begin vc = cycn - t0; break; end
      @(negedge clk);
    end
    total_n++;
    if (vc !== 77) $display("FAIL reseed32_valid_cycle: got %0d expected 77", vc); else pass_n++;
    total_n++;
    if (word32 !== 32'h92492492) $display("FAIL reseed32_word: got %h expected 92492492", word32); else pass_n++;
    total_n++;
    if (wn32 !== 6) $display("FAIL reseed32_write_count: got %0d expected 6", wn32); else pass_n++;
    for (int i = 0; i < 6; i++) begin
      total_n++;
      if (wa32[i] !== ea[i]) $display("FAIL reseed32_addr%0d: got %0d expected %0d", i, wa32[i], ea[i]); else pass_n++;
      total_n++;
      if (wd32[i] !== ed[i]) $display("FAIL reseed32_data%0d: got %h expected %h", i, wd32[i], ed[i]); else pass_n++;
    end
    total_n++;
    if (rn32 !== 32) $display("FAIL reseed32_read_count: got %0d expected 32", rn32); else pass_n++;
    total_n++;
    if (bad32 !== 1'b0) $display("FAIL reseed32_write_after_read: got %b expected 0", bad32); else pass_n++;
  endtask

  task automatic test_noreseed8(output int bl);
    int vc, ec, nv, ne;
    logic ce;
    setpat(8'hB2, 8'h5C);
    clear8();
    start8(1'b0, 32'h0);
    wait8(100, vc, ec, bl, nv, ne, ce);
    total_n++;
    if (vc !== 17) $display("FAIL pack8_valid_cycle: got %0d expected 17", vc); else pass_n++;
    total_n++;
    if (word8 !== 8'hB2) $display("FAIL pack8_word: got %h expected b2", word8); else pass_n++;
    total_n++;
    if (bl !== 18) $display("FAIL pack8_busy_low_cycle: got %0d expected 18", bl); else pass_n++;
    total_n++;
    if (nv !== 1 || ne !== 0) $display("FAIL pack8_pulses: got valid=%0d err=%0d expected 1/0", nv, ne); else pass_n++;
  endtask

  // starts in the very cycle the previous run leaves busy, reading the next 8 pattern bits
  task automatic test_back_to_back();
    int vc, ec, bl, nv, ne;
    logic ce;
    start8(1'b0, 32'h0);
    wait8(100, vc, ec, bl, nv, ne, ce);
    total_n++;
    if (vc !== 17) $display("FAIL b2b_valid_cycle: got %0d expected 17", vc); else pass_n++;
    total_n++;
    if (word8 !== 8'h5C) $display("FAIL b2b_word: got %h expected 5c", word8); else pass_n++;
  endtask

  task automatic test_start_while_busy();
    int vc, ec, bl, nv, ne;
    logic ce;
    setpat(8'hB2, 8'h00);
    clear8();
    start8(1'b0, 32'h0);
    repeat (4) @(negedge clk);
    st8 = 1'b1; rs8 = 1'b1; sd8 = 32'hFFFFFFFF;
    @(negedge clk);
    st8 = 1'b0; rs8 = 1'b0; sd8 = 32'h0;
    wait8(100, vc, ec, bl, nv, ne, ce);
    total_n++;
    if (vc !== 17) $display("FAIL busy_start_valid_cycle: got %0d expected 17", vc); else pass_n++;
    total_n++;
    if (word8 !== 8'hB2) $display("FAIL busy_start_word: got %h expected b2", word8); else pass_n++;
    total_n++;
    if (wr8 !== 0) $display("FAIL busy_start_writes: got %0d expected 0", wr8); else pass_n++;
    total_n++;
    if (nv !== 1) $display("FAIL busy_start_valid_pulses: got %0d expected 1", nv); else pass_n++;
  endtask

  task automatic test_stall();
    int vc, ec, bl, nv, ne;
    logic ce;
    setpat(8'h3C, 8'h00);
    clear8();
    stall8 = 1'b1;
    start8(1'b1, 32'h123456A5);
    for (int c = 1; c <= 4; c++) begin
      total_n++;
      if ({stb8, we8, adr8, dat8} !== {1'b1, 1'b1, 3'd0, 8'hA5})
        $display("FAIL stall_hold_c%0d: got stb=%b we=%b addr=%0d data=%h expected 1 1 0 a5", c, stb8, we8, adr8, dat8);
      else pass_n++;
      if (c < 4) @(negedge clk);
    end
    stall8 = 1'b0;
    wait8(100, vc, ec, bl, nv, ne, ce);
    total_n++;
    if (vc !== 32) $display("FAIL stall_valid_cycle: got %0d expected 32", vc); else pass_n++;
    total_n++;
    if (word8 !== 8'h3C) $display("FAIL stall_word: got %h expected 3c", word8); else pass_n++;
  endtask

  task automatic test_timeout();
    int vc, ec, bl, nv, ne;
    logic ce;
    setpat(8'hB2, 8'h00);
    clear8();
    drop8 = 2;
    start8(1'b0, 32'h0);
    wait8(80, vc, ec, bl, nv, ne, ce);
    total_n++;
    if (ne !== 1) $display("FAIL timeout_err_pulses: got %0d expected 1", ne); else pass_n++;
    total_n++;
    if (nv !== 0) $display("FAIL timeout_no_valid: got %0d expected 0", nv); else pass_n++;
    total_n++;
    if (ce !== 1'b0) $display("FAIL timeout_cyc_dropped: got %b expected 0", ce); else pass_n++;
    total_n++;
    if (word8 !== 8'h3C) $display("FAIL timeout_word_kept: got %h expected 3c", word8); else pass_n++;
    total_n++;
    if (bl !== ec + 1) $display("FAIL timeout_busy_low: got %0d expected %0d", bl, ec + 1); else pass_n++;
    drop8 = -1;
    clear8();
    start8(1'b0, 32'h0);
    wait8(100, vc, ec, bl, nv, ne, ce);
    total_n++;
    if (vc !== 17 || word8 !== 8'hB2)
      $display("FAIL timeout_recover: got cycle=%0d word=%h expected 17 b2", vc, word8);
    else pass_n++;
  endtask

  task automatic test_reset_midrun();
    int vc, ec, bl, nv, ne;
    logic ce;
    setpat(8'hB2, 8'h00);
    clear8();
    start8(1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_n++;
    if ({busy8, val8, err8, cyc8, stb8, we8, adr8, dat8, word8} !== 30'h0)
      $display("FAIL midrun_reset_u8: got %h expected 0", {busy8, val8, err8, cyc8, stb8, we8, adr8, dat8, word8});
    else pass_n++;
    total_n++;
    if (word32 !== 32'h0) $display("FAIL midrun_reset_u32_word: got %h expected 0", word32); else pass_n++;
    @(negedge clk);
    clear8();
    rst_n = 1'b1;
    start8(1'b0, 32'h0);
    wait8(100, vc, ec, bl, nv, ne, ce);
    total_n++;
    if (vc !== 17) $display("FAIL midrun_rerun_cycle: got %0d expected 17", vc); else pass_n++;
    total_n++;
    if (word8 !== 8'hB2) $display("FAIL midrun_rerun_word: got %h expected b2", word8); else pass_n++;
  endtask

  initial begin
    int bl;
    test_reset();
    test_reseed32();
    test_noreseed8(bl);
    test_back_to_back();
    test_start_while_busy();
    @(negedge clk);
    test_stall();
    @(negedge clk);
    test_timeout();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", pass_n, total_n);
    $fatal(1);
  end

endmodule
